spi_target: RTL and testbench
=============================

// Module: spi_target
// PURPOSE
//  - Peripheral-side SPI endpoint: the device on the far end of the SPI master's spi_clk/cs/mosi/miso wires.
//  - Shifts in master bytes on mosi and returns holding-register bytes on miso.
//  - Serves as the loop-back partner for master benches and as the slave interface for on-chip register access.
//  - All SPI pins are oversampled in the clk domain; no logic runs on spi_clk.
// PARAMETERS
//  DATA_W       8   bits per SPI word, MSB first
//  SYNC_STAGES  2   flip-flop stages on spi_clk, cs and mosi (minimum 2)
// PORTS
//  clk       in   1       system clock; spi_clk half-period >= SYNC_STAGES+2 clk periods
//  reset     in   1       asynchronous, active-low; 0 = reset
//  spi_clk   in   1       SPI serial clock from master
//  cs        in   1       chip select, active-low
//  mosi      in   1       master-out serial data
//  miso      out  1       slave-out serial data
//  polarity  in   1       CPOL; sampled only while cs=1
//  phase     in   1       CPHA; sampled only while cs=1
//  tx_data   in   DATA_W  next word to return to master
//  tx_valid  in   1       tx_data valid
//  tx_ready  out  1       holding register empty; transfer on tx_valid&tx_ready
//  rx_data   out  DATA_W  last complete received word (held)
//  rx_valid  out  1       one-clk pulse per complete word
//  tx_underrun out 1      one-clk pulse: word started with holding register empty
//  frame_err out  1       one-clk pulse: cs rose with 0 < bit_cnt < DATA_W
//  state     out  2       FSM state (debug)
//  count     out  4       bits shifted in the current word (debug)
// BEHAVIOUR
//  - Reset values: miso=1, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0, state=IDLE, count=0; holding and shift registers cleared.
//  - Edges: lead edge = rising if polarity=0, else falling; trail edge = the opposite.
//  - CPHA=0: sample mosi on lead, shift miso on trail. CPHA=1: shift miso on lead, sample mosi on trail.
//  - Edge detection runs on synchronized spi_clk. The sample uses synchronized mosi aligned to the same stage.
//  - FSM IDLE (cs=1): miso=1; polarity/phase latched into mode register.
//    - cs falling -> LOAD.
//  - LOAD, one cycle:
//    - shift_reg <= holding register if full (tx_ready<=1), else 8'hFF plus tx_underrun pulse.
//    - CPHA=0: miso <= shift_reg MSB immediately.
//    - -> SHIFT.
//  - SHIFT: each sample edge does rx_shift <= {rx_shift, mosi}; count++.
//    - Each shift edge puts the next bit on miso. For CPHA=1 the first shift edge puts out the MSB.
//    - When count reaches DATA_W: rx_data <= word and rx_valid pulses the next cycle, count <= 0, -> LOAD.
//    - Back-to-back words need no cs toggle.
//  - Latency: miso update and rx_valid <= SYNC_STAGES+2 clk after the pin edge.
//  - cs rising in any state -> IDLE, same cycle as detection.
//    - Partial word discarded, no rx_valid.
//    - frame_err pulses if 0 < count < DATA_W; count <= 0.
//  - tx handshake: the holding register is written on tx_valid&tx_ready, and tx_ready drops the next cycle.
//    - Simultaneous LOAD and tx write: LOAD takes the old contents (or 8'hFF if empty); the new write lands in the holding register.
//  - No rx back-pressure: a new word overwrites rx_data.
//  - Reset asserted mid-frame: immediate return to reset values. After release, stay IDLE until cs is seen high, then falling.
// CONFIGURATION
//  - SPI_TGT_ECHO_EN defined: on underrun, shift_reg loads the previous rx_data (loop-back) instead of 8'hFF. tx_underrun still pulses.
//  - Not defined: underrun loads 8'hFF.
// STRUCTURE
//  - Package spi_pkg: state encodings IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2; SPI_IDLE_WORD=8'hFF; mode bit positions.
//  - Sub-module spi_edge_sync: SYNC_STAGES synchronizer plus rise/fall pulse detect; one instance each for spi_clk and cs; mosi uses synchronizer only.
// TESTING
//  1. Mode 3 (pol=1, pha=1), preload tx 8'h5A, master sends 8'hAF -> rx_data=8'hAF, one rx_valid, miso bits 0,1,0,1,1,0,1,0.
//  2. Mode 0, preload 8'hC3, master sends 8'h3C -> rx_data=8'h3C; miso=1 (MSB) before the first rising spi_clk edge.
//  3. Two words, cs held low, tx 8'h11 then 8'h22 written while tx_ready -> rx_valid x2, miso returns 8'h11 then 8'h22.
//  4. Empty holding register, master sends 8'h0F -> tx_underrun pulse, miso 8'hFF; with SPI_TGT_ECHO_EN, second word returns 8'h0F.
//  5. cs raised after 3 bits -> frame_err pulse, no rx_valid, count=0; the next full frame is received correctly.
//  6. reset=0 at bit 5 -> all outputs at reset values within 1 clk; the next frame after release is correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: FSM state encodings, idle word, mode bit positions.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

    localparam logic [7:0] SPI_IDLE_WORD = 8'hFF;

    localparam int MODE_CPHA_BIT = 0;
    localparam int MODE_CPOL_BIT = 1;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for an asynchronous pin with rise/fall pulse detection
// on the synchronized level.
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   prev_p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p <= {SYNC_STAGES{RST_VAL}};
            prev_p <= RST_VAL;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], din};
            prev_p <= sync_p[SYNC_STAGES-1];
        end
    end

    assign sync = sync_p[SYNC_STAGES-1];
    assign rise = sync & ~prev_p;
    assign fall = ~sync & prev_p;

endmodule

// File: rtl/spi_target.sv
// Oversampled SPI target (all four CPOL/CPHA modes, MSB first, single holding register).
// Define SPI_TGT_ECHO_EN to return the previous rx_data on underrun instead of the idle word.
module spi_target
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic              polarity,
    input  logic              phase,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err,
    output logic [1:0]        state,
    output logic [3:0]        count
);

    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_p;
    logic mosi_s;

    logic [1:0]        mode_q;
    spi_state_t        state_q, state_d;
    logic [3:0]        count_q;
    logic [DATA_W-1:0] rx_shift_q, tx_shift_q, hold_q, load_word;
    logic              hold_full_q;

    logic cpol, cpha, lead, trail, sample_edge, shift_edge;
    logic do_load, do_sample, do_shift, word_done, abort;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(spi_clk),
        .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    // cs resets low so a frame already in progress at release never looks like a fresh falling edge
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk(clk), .reset(reset), .din(cs),
        .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mosi_p <= '0;
        else        mosi_p <= {mosi_p[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_p[SYNC_STAGES-1];

    assign cpol        = mode_q[MODE_CPOL_BIT];
    assign cpha        = mode_q[MODE_CPHA_BIT];
    assign lead        = cpol ? sclk_fall : sclk_rise;
    assign trail       = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail : lead;
    assign shift_edge  = cpha ? lead  : trail;

    always_comb begin
        if (hold_full_q)
            load_word = hold_q;
        else
`ifdef SPI_TGT_ECHO_EN
            load_word = rx_data;
`else
            load_word = {DATA_W{SPI_IDLE_WORD[0]}};
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_load   = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        word_done = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE:  if (cs_fall) state_d = LOAD;
            LOAD: begin
                do_load = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                do_sample = sample_edge;
                // CPHA=0: the trail edge closing the last bit must not disturb the MSB already loaded
                do_shift  = shift_edge && (cpha || count_q != 4'd0);
                if (sample_edge && count_q == 4'(DATA_W - 1)) begin
                    word_done = 1'b1;
                    state_d   = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cs_rise) begin
            state_d   = IDLE;
            abort     = 1'b1;
            do_load   = 1'b0;
            do_sample = 1'b0;
            do_shift  = 1'b0;
            word_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q      <= '0;
            count_q     <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso        <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            if (state_q == IDLE && cs_sync)
                mode_q <= {polarity, phase};
            // only an empty register accepts a write, so a concurrent LOAD always sees it empty
            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end else if (do_load) begin
                hold_full_q <= 1'b0;
            end
            if (abort) begin
                miso      <= 1'b1;
                count_q   <= '0;
                frame_err <= (count_q != 4'd0);
            end else if (state_q == IDLE) begin
                miso <= 1'b1;
            end else begin
                if (do_load) begin
                    tx_underrun <= !hold_full_q;
                    if (cpha) begin
                        tx_shift_q <= load_word;
                    end else begin
                        tx_shift_q <= {load_word[DATA_W-2:0], 1'b1};
                        miso       <= load_word[DATA_W-1];
                    end
                end
                if (do_shift) begin
                    miso       <= tx_shift_q[DATA_W-1];
                    tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b1};
                end
                if (do_sample) begin
                    rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (word_done) begin
                        rx_data  <= {rx_shift_q[DATA_W-2:0], mosi_s};
                        rx_valid <= 1'b1;
                        count_q  <= '0;
                    end else begin
                        count_q <= count_q + 4'd1;
                    end
                end
            end
        end
    end

    assign tx_ready = ~hold_full_q;
    assign state    = state_q;
    assign count    = count_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-banged SPI master, hand-computed expected words.
module tb_spi_target;

    localparam int HALF = 8;
`ifdef SPI_TGT_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spi_clk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       polarity = 1'b0;
    logic       phase = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_err;
    logic [1:0] state;
    logic [3:0] count;

    int n_vec = 0;
    int n_miss = 0;
    int n_rxv = 0;
    int n_udr = 0;
    int n_ferr = 0;
    logic [7:0] last_rx = '0;
    logic m_pol = 1'b0;
    logic m_pha = 1'b0;

    spi_target #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs(cs), .mosi(mosi), .miso(miso),
        .polarity(polarity), .phase(phase), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_err(frame_err), .state(state), .count(count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_rxv++;
            last_rx = rx_data;
        end
        if (tx_underrun) n_udr++;
        if (frame_err)   n_ferr++;
    end

    task automatic vec_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tx_push(input logic [7:0] d);
        int waited = 0;
        @(negedge clk);
        while (!tx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) vec_check("tx_ready_timeout", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_begin(input logic pol, input logic pha);
        @(negedge clk);
        m_pol = pol; m_pha = pha;
        polarity = pol; phase = pha;
        spi_clk = pol; cs = 1'b1; mosi = 1'b0;
        repeat (6) @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            if (!m_pha) begin
                repeat (HALF) @(negedge clk);
                rx[i] = miso;
                spi_clk = ~m_pol;
                repeat (HALF) @(negedge clk);
                spi_clk = m_pol;
            end else begin
                spi_clk = ~m_pol;
                repeat (HALF) @(negedge clk);
                rx[i] = miso;
                spi_clk = m_pol;
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [7:0] r0, r1;
        int rxv0, udr0, fe0;

        // reset state
        repeat (3) @(negedge clk);
        vec_check("rst_miso", 32'(miso), 32'd1);
        vec_check("rst_tx_ready", 32'(tx_ready), 32'd1);
        vec_check("rst_rx_data", 32'(rx_data), 32'h0);
        vec_check("rst_rx_valid", 32'(rx_valid), 32'd0);
        vec_check("rst_state", 32'(state), 32'd0);
        vec_check("rst_count", 32'(count), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 1: mode 3
        rxv0 = n_rxv;
        tx_push(8'h5A);
        vec_check("t1_tx_ready_full", 32'(tx_ready), 32'd0);
        cs_begin(1'b1, 1'b1);
        spi_bits(8'hAF, 8, r0);
        cs_end();
        vec_check("t1_rx_data", 32'(rx_data), 32'hAF);
        vec_check("t1_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd1);
        vec_check("t1_miso_word", 32'(r0), 32'h5A);

        // 2: mode 0, MSB must be on miso before first rising edge
        rxv0 = n_rxv;
        tx_push(8'hC3);
        cs_begin(1'b0, 1'b0);
        vec_check("t2_miso_msb_early", 32'(miso), 32'd1);
        spi_bits(8'h3C, 8, r0);
        cs_end();
        vec_check("t2_rx_data", 32'(rx_data), 32'h3C);
        vec_check("t2_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd1);
        vec_check("t2_miso_word", 32'(r0), 32'hC3);

        // 3: mode 1, two back-to-back words
        rxv0 = n_rxv;
        tx_push(8'h11);
        cs_begin(1'b0, 1'b1);
        tx_push(8'h22);
        spi_bits(8'hA5, 8, r0);
        vec_check("t3_rx_word1", 32'(last_rx), 32'hA5);
        spi_bits(8'h3C, 8, r1);
        cs_end();
        vec_check("t3_rx_word2", 32'(rx_data), 32'h3C);
        vec_check("t3_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd2);
        vec_check("t3_miso_word1", 32'(r0), 32'h11);
        vec_check("t3_miso_word2", 32'(r1), 32'h22);

        // 4: underrun, holding register empty for the whole frame
        udr0 = n_udr;
        cs_begin(1'b0, 1'b0);
        spi_bits(8'h0F, 8, r0);
        spi_bits(8'h81, 8, r1);
        cs_end();
        vec_check("t4_miso_word1", 32'(r0), ECHO ? 32'h3C : 32'hFF);
        vec_check("t4_miso_word2", 32'(r1), ECHO ? 32'h0F : 32'hFF);
        vec_check("t4_underrun_cnt", 32'(n_udr - udr0), 32'd3);
        vec_check("t4_rx_data", 32'(rx_data), 32'h81);

        // 5: cs raised after 3 bits, then a clean frame
        rxv0 = n_rxv; fe0 = n_ferr;
        cs_begin(1'b0, 1'b0);
        spi_bits(8'hE0, 3, r0);
        cs_end();
        vec_check("t5_frame_err_cnt", 32'(n_ferr - fe0), 32'd1);
        vec_check("t5_no_rx_valid", 32'(n_rxv - rxv0), 32'd0);
        vec_check("t5_count_cleared", 32'(count), 32'd0);
        vec_check("t5_rx_data_held", 32'(rx_data), 32'h81);
        tx_push(8'h69);
        cs_begin(1'b0, 1'b0);
        spi_bits(8'h96, 8, r0);
        cs_end();
        vec_check("t5_next_rx_data", 32'(rx_data), 32'h96);
        vec_check("t5_next_miso", 32'(r0), 32'h69);
        vec_check("t5_next_frame_err", 32'(n_ferr - fe0), 32'd1);

        // 6: reset asserted at bit 5
        tx_push(8'h24);
        cs_begin(1'b0, 1'b0);
        spi_bits(8'hB4, 5, r0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vec_check("t6_miso", 32'(miso), 32'd1);
        vec_check("t6_tx_ready", 32'(tx_ready), 32'd1);
        vec_check("t6_rx_data", 32'(rx_data), 32'h0);
        vec_check("t6_pulses", 32'({rx_valid, tx_underrun, frame_err}), 32'd0);
        vec_check("t6_state", 32'(state), 32'd0);
        vec_check("t6_count", 32'(count), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rxv0 = n_rxv;
        for (int k = 0; k < 4; k++) begin
            spi_clk = ~spi_clk;
            repeat (HALF) @(negedge clk);
        end
        vec_check("t6_idle_after_release", 32'(state), 32'd0);
        vec_check("t6_no_rx_after_release", 32'(n_rxv - rxv0), 32'd0);
        cs_end();
        tx_push(8'hE7);
        cs_begin(1'b0, 1'b0);
        spi_bits(8'h5C, 8, r0);
        cs_end();
        vec_check("t6_next_rx_data", 32'(rx_data), 32'h5C);
        vec_check("t6_next_miso", 32'(r0), 32'hE7);
        vec_check("t6_next_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
